// File: rtl/adcv_pkg.sv
// Shared definitions for the ADC sample averager: state encoding, the data width
// shared with the ADC top level, and the rounding-offset helper.
package adcv_pkg;

   localparam int ADCV_DATA_BITS = 10;

   localparam logic ST_SETTLE = 1'b0;
   localparam logic ST_ACCUM  = 1'b1;

   // Half an LSB of the averaged result; zero when windows are a single sample.
   function automatic int round_offset(input int log2_n);
      return (log2_n == 0) ? 0 : (1 << (log2_n - 1));
   endfunction

endpackage

// File: rtl/adcv_out_stage.sv
// One-entry valid/ready result register for the averager, plus a saturating
// count of results lost because the register was still occupied.
module adcv_out_stage #(
   parameter int DATA_BITS = 10,
   parameter int SUM_BITS  = 14,
   parameter int DROP_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] avg_in,
   input  logic [SUM_BITS-1:0]  sum_in,
   input  logic                 avg_ready,
   output logic [DATA_BITS-1:0] avg_out,
   output logic [SUM_BITS-1:0]  sum_out,
   output logic                 avg_valid,
   output logic [DROP_BITS-1:0] drop_count
);

   // A new result wins over consumption; it only gets dropped when the old one is still unread.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         avg_out    <= '0;
         sum_out    <= '0;
         avg_valid  <= 1'b0;
         drop_count <= '0;
      end else if (load) begin
         if (!avg_valid || avg_ready) begin
            avg_out   <= avg_in;
            sum_out   <= sum_in;
            avg_valid <= 1'b1;
         end else if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
         end
      end else if (avg_valid && avg_ready) begin
         avg_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/adc_sample_averager.sv
// Boxcar averager for the ramp ADC: skips settling samples after enable, then
// emits one rounded mean per 2^LOG2_N accepted conversions.
module adc_sample_averager
   import adcv_pkg::*;
#(
   parameter int DATA_BITS = ADCV_DATA_BITS,
   parameter int LOG2_N    = 4,
   parameter int SKIP      = 4,
   parameter int DROP_BITS = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [DATA_BITS-1:0]        sample_in,
   input  logic                        sample_valid,
   output logic [DATA_BITS-1:0]        avg_out,
   output logic [DATA_BITS+LOG2_N-1:0] sum_out,
   output logic                        avg_valid,
   input  logic                        avg_ready,
   output logic [DROP_BITS-1:0]        drop_count,
   output logic                        busy
);

   localparam int SUM_BITS = DATA_BITS + LOG2_N;
   localparam int CNT_BITS = 8;
   localparam logic [CNT_BITS-1:0] WIN_LAST  = CNT_BITS'((1 << LOG2_N) - 1);
   localparam logic [CNT_BITS-1:0] SKIP_LAST = CNT_BITS'((SKIP > 0) ? SKIP - 1 : 0);
   localparam logic [SUM_BITS:0]   ROUND_ADD = (SUM_BITS + 1)'(round_offset(LOG2_N));

   logic                 state, next_state;
   logic [SUM_BITS-1:0]  acc, next_acc, win_total;
   logic [CNT_BITS-1:0]  cnt, next_cnt;
   logic                 win_done;
   logic                 accept;
   logic [SUM_BITS:0]    rounded;
   logic [DATA_BITS-1:0] win_avg;

   assign accept    = enable && sample_valid;
   assign win_total = acc + SUM_BITS'(sample_in);
   assign rounded   = {1'b0, win_total} + ROUND_ADD;
   assign win_avg   = DATA_BITS'(rounded >> LOG2_N);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_SETTLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= next_state;
         acc   <= next_acc;
         cnt   <= next_cnt;
      end
   end

   // Dropping enable always restarts settling, so a partial window never leaks out.
   always_comb begin
      next_state = state;
      next_acc   = acc;
      next_cnt   = cnt;
      win_done   = 1'b0;
      if (!enable) begin
         next_state = ST_SETTLE;
         next_acc   = '0;
         next_cnt   = '0;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (SKIP == 0) begin
                  next_state = ST_ACCUM;
               end else if (accept) begin
                  if (cnt == SKIP_LAST) begin
                     next_state = ST_ACCUM;
                     next_cnt   = '0;
                  end else begin
                     next_cnt = cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (accept) begin
                  if (cnt == WIN_LAST) begin
                     win_done = 1'b1;
                     next_acc = '0;
                     next_cnt = '0;
                  end else begin
                     next_acc = win_total;
                     next_cnt = cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      busy = (state == ST_ACCUM);
   end

   adcv_out_stage #(
      .DATA_BITS(DATA_BITS),
      .SUM_BITS (SUM_BITS),
      .DROP_BITS(DROP_BITS)
   ) u_out_stage (
      .clock     (clock),
      .reset     (reset),
      .load      (win_done),
      .avg_in    (win_avg),
      .sum_in    (win_total),
      .avg_ready (avg_ready),
      .avg_out   (avg_out),
      .sum_out   (sum_out),
      .avg_valid (avg_valid),
      .drop_count(drop_count)
   );

endmodule
